// File: rtl/load_store_unit.sv
// Data-memory front end: one load/store at a time to a byte-enabled RAM with
// one-cycle registered read latency; misaligned/illegal requests never reach memory.
//
// state | meaning
// IDLE  | ready to accept a request
// ISSUE | RAM address/byte enables/write strobe presented
// WAIT  | RAM read data valid, lane extracted into resp_rdata
// RESP  | one-cycle response strobe (also the direct target of rejected requests)
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [3:0]               mem_be,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      r_state, r_next;
  logic        r_we;
  logic        r_err;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;

  logic        w_accept;
  logic        w_legal;
  logic        w_aligned;
  logic        w_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_accept = req_valid && (r_state == IDLE);

  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wdata   = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !req_we;
      default:                w_legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_aligned = !req_addr[0];
        w_be      = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{req_wdata[15:0]}};
      end
      default: w_aligned = (req_addr[1:0] == 2'b00);
    endcase
    w_ok = w_legal && w_aligned;
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) r_next = w_ok ? ISSUE : RESP;
      end
      ISSUE: r_next = WAIT;
      WAIT:  r_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        r_next     = IDLE;
      end
      default: r_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_funct3   <= 3'd0;
      r_lane     <= 2'd0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_be     <= 4'd0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_we       <= req_we;
          r_err      <= !w_ok;
          r_funct3   <= req_funct3;
          r_lane     <= req_addr[1:0];
          resp_rdata <= '0;
          if (w_ok) begin
            mem_addr <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
            if (req_we) begin
              mem_we    <= 1'b1;
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          mem_be <= 4'd0;
        end
        WAIT: if (!r_we) resp_rdata <= w_load;
        default: ;
      endcase
    end
  end

endmodule
